spart_driver: RTL
=================

// Module: spart_driver
// PURPOSE
//  Bus master that sequences the SPART on the processor side. After reset it programs the
//  16-bit baud divisor from the DIP-switch code. It then runs an echo loop:
//  wait for rda -> read receive buffer -> wait for tbr -> write byte to transmit buffer.
//  Sits between the board DIP switches and the SPART bus (iocs/iorw/ioaddr/databus).
//  It is the only master on that bus.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency; only documents the package divisor table
// PORTS
//  clk        in     1  system clock; all logic on posedge
//  rst        in     1  reset; synchronous, active-high
//  br_cfg     in     2  DIP baud select: 00=4800 01=9600 10=19200 11=38400
//  rda        in     1  SPART receive data available
//  tbr        in     1  SPART transmit buffer ready
//  iocs       out    1  SPART chip select; one-cycle pulse per access
//  iorw       out    1  1=read, 0=write
//  ioaddr     out    2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high
//  databus    inout  8  driven only in a write cycle (iocs & !iorw); else 8'hzz
//  echo_cnt   out    8  bytes echoed (present only with SPART_DRV_BYTE_CNT_EN)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus=z, byte_q=0, br_q=br_cfg.
//   - Reset mid-access aborts it. No partial write survives the reset edge; the cycle after
//     rst deasserts is CFG_LO.
//  Outputs are registered (Moore); each bus access is exactly one cycle of iocs=1.
//  States:
//   CFG_LO : iocs=1 iorw=0 ioaddr=10 databus=DIV[br_q][7:0]                  -> CFG_HI
//   CFG_HI : iocs=1 iorw=0 ioaddr=11 databus=DIV[br_q][15:8]                 -> IDLE
//   IDLE   : iocs=0 iorw=1.
//            - If br_cfg != br_q: load br_q <= br_cfg, then -> CFG_LO.
//            - Else if rda: -> RX_RD.
//            - Else stay.
//   RX_RD  : iocs=1 iorw=1 ioaddr=00; byte_q <= databus on this cycle's edge   -> TX_WAIT
//   TX_WAIT: iocs=0; stay until tbr=1                                       -> TX_WR
//   TX_WR  : iocs=1 iorw=0 ioaddr=00 databus=byte_q                          -> IDLE
//  Latency: rda seen in IDLE -> read at +1 cycle -> write at +3 cycles if tbr is already 1.
//  Priority in IDLE: a baud change beats rda.
//   - A pending rda is serviced after reconfiguration (2 cycles later); the byte is not lost.
//   - br_cfg changes outside IDLE are deferred until the next IDLE.
//  br_cfg is double-flop synchronised before comparison. The CFG path uses the synced value.
//  tbr never rises: the FSM waits in TX_WAIT indefinitely; no timeout. Only rst recovers.
//  A new rda while in TX_WAIT is ignored until return to IDLE. The SPART holds rda.
// CONFIGURATION
//  `define SPART_DRV_BYTE_CNT_EN
//   - Defined: echo_cnt port exists. Reset 0. Increments (mod 256, 8'hFF -> 8'h00) on
//     each TX_WR cycle.
//   - Not defined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package spart_pkg:
//   - typedef enum logic [2:0] drv_state_t {CFG_LO,CFG_HI,IDLE,RX_RD,TX_WAIT,TX_WR}.
//   - IOADDR_BUF=2'b00, IOADDR_STAT=2'b01, IOADDR_DBL=2'b10, IOADDR_DBH=2'b11.
//   - DIV table, divisor = CLK_HZ/baud (full bit period):
//     4800=16'h28B1, 9600=16'h1458, 19200=16'h0A2C, 38400=16'h0516.
//  Sub-module: spart_drv_sync (2-flop synchroniser, width param) for br_cfg.
//  Everything else is flat.
// TESTING (bench models the SPART register file + rda/tbr)
//  1. rst 2 cycles, br_cfg=01 ->
//     - CFG_LO write ioaddr=10 data 8'h58
//     - next cycle CFG_HI write ioaddr=11 data 8'h14
//     - then iocs=0
//  2. rda=1 with rx buf 8'hA5, tbr=1 ->
//     - read pulse (ioaddr=00, iorw=1) 1 cycle after IDLE
//     - write of 8'hA5 to ioaddr=00 two cycles later
//  3. rda=1 with byte 8'h3C, tbr=0 for 20 cycles ->
//     - iocs stays 0 for those 20 cycles
//     - write of 8'h3C 1 cycle after tbr rises
//  4. br_cfg 01->11 while in TX_WAIT ->
//     - no CFG access until after TX_WR
//     - then writes 8'h16 then 8'h05
//  5. rst pulsed during TX_WAIT ->
//     - databus=z, iocs=0 next cycle
//     - then CFG_LO/CFG_HI sequence repeats; no stale write
//  6. SPART_DRV_BYTE_CNT_EN: echo 257 bytes -> echo_cnt=8'h01. Without the macro the
//     bench compiles with no echo_cnt port.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared FSM states, SPART register addresses and baud divisor table for spart_driver.
package spart_pkg;
    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_RD, TX_WAIT, TX_WR} drv_state_t;

    localparam logic [1:0] IOADDR_BUF  = 2'b00;
    localparam logic [1:0] IOADDR_STAT = 2'b01;
    localparam logic [1:0] IOADDR_DBL  = 2'b10;
    localparam logic [1:0] IOADDR_DBH  = 2'b11;

    // Rounded CLK_HZ/baud for 4800, 9600, 19200, 38400.
    function automatic logic [15:0] div_of(input logic [1:0] br);
        return br == 2'b00 ? 16'h28B1 :
               br == 2'b01 ? 16'h1458 :
               br == 2'b10 ? 16'h0A2C : 16'h0516;
    endfunction
endpackage

// File: rtl/spart_drv_sync.sv
// spart_drv_sync: two-flop synchroniser for quasi-static board inputs.
module spart_drv_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end
endmodule

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from the DIP switches, then echoes received bytes.
// Optional echo byte counter port enabled with `define SPART_DRV_BYTE_CNT_EN.
module spart_driver
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
`ifdef SPART_DRV_BYTE_CNT_EN
    output logic [7:0] echo_cnt,
`endif
    inout  wire  [7:0] databus
);
    drv_state_t state, nxt;
    logic [1:0]  br_s, br_q;
    logic [7:0]  byte_q, dout;
    logic [15:0] div;
    logic        run;

    spart_drv_sync #(.W(2)) u_sync (.clk(clk), .d(br_cfg), .q(br_s));

    // run holds the FSM for one cycle after reset so CFG_LO is seen on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CFG_LO;
            run    <= 1'b0;
            byte_q <= 8'h00;
            br_q   <= br_cfg;
        end else begin
            run   <= 1'b1;
            state <= nxt;
            if (run && state == RX_RD) byte_q <= databus;
            if (run && state == IDLE && br_s != br_q) br_q <= br_s;
        end
    end

    always_comb begin
        nxt = state;
        if (run) begin
            case (state)
                CFG_LO:  nxt = CFG_HI;
                CFG_HI:  nxt = IDLE;
                IDLE:    nxt = br_s != br_q ? CFG_LO : rda ? RX_RD : IDLE;
                RX_RD:   nxt = TX_WAIT;
                TX_WAIT: nxt = tbr ? TX_WR : TX_WAIT;
                TX_WR:   nxt = IDLE;
                default: nxt = CFG_LO;
            endcase
        end
    end

    always_comb begin
        div    = div_of(br_q);
        iocs   = run && (state == CFG_LO || state == CFG_HI || state == RX_RD || state == TX_WR);
        iorw   = !(run && (state == CFG_LO || state == CFG_HI || state == TX_WR));
        ioaddr = !run             ? IOADDR_BUF :
                 state == CFG_LO  ? IOADDR_DBL :
                 state == CFG_HI  ? IOADDR_DBH : IOADDR_BUF;
        dout   = state == CFG_LO ? div[7:0] : state == CFG_HI ? div[15:8] : byte_q;
    end

    assign databus = (iocs && !iorw) ? dout : 8'hzz;

`ifdef SPART_DRV_BYTE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) echo_cnt <= 8'h00;
        else if (run && state == TX_WR) echo_cnt <= echo_cnt + 8'h01;
    end
`endif
endmodule
